// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e       : memory-wait FSM encoding (RUN / WAIT / ERR)
//   stage_ctrl_t  : bundle of per-stage enables and bubble/flush strobes
//   CTRL_*        : the fixed control patterns chosen by the output mux
//   REG_X0        : hard-wired zero register, never a real hazard source
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } stage_ctrl_t;

    // Everything held, nothing injected: used while reset is asserted.
    localparam stage_ctrl_t CTRL_NOP    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Whole front end frozen; MEM/WB gets a NOP so WB does not retire twice.
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Redirect: load the new PC, squash the two wrong-path instructions.
    localparam stage_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Load-use: hold PC and IF/ID, insert one bubble into EX.
    localparam stage_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // Normal flow.
    localparam stage_ctrl_t CTRL_NONE   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the instruction in EX is a load whose destination (non-zero)
// is read by the instruction currently in ID.
//   id_rs1_i / id_rs2_i           : ID source register numbers
//   id_rs1_used_i / id_rs2_used_i : the corresponding source is really read
//   ex_rd_i                       : EX destination register
//   ex_mem_read_i                 : EX instruction is a load
//   lu_o                          : load-use hazard this cycle
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    output logic       lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign lu_o    = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges three hazard sources (memory freeze > taken branch > load-use) into
// per-stage write enables and bubble/flush strobes, all combinational from
// the current FSM state and inputs.  Also keeps three saturating performance
// counters and a sticky memory-timeout error.
//   clk_i, rst_i (async, active low)
//   ID_Rs1/ID_Rs2/ID_Rs1_used/ID_Rs2_used, EX_Rd, EX_MemRead : load-use inputs
//   EX_BranchTaken                                           : PC redirect
//   MEM_MemAccess, dmem_ack_i / dmem_req_o                   : data memory handshake
//   PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
//   EXMEM_Write, MEMWB_Bubble                                : stage controls
//   err_o                                                    : sticky timeout
//   stall_cnt_o / flush_cnt_o / mstall_cnt_o                 : perf counters
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_Rs1_used,
    input  logic             ID_Rs2_used,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemAccess,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] mstall_cnt_o
);

    localparam int WC_W = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              freeze;
    logic              req;
    logic              lu;
    logic              sel_branch;
    logic              sel_lu;
    stage_ctrl_t       ctrl;

    load_use_detect u_lu (
        .id_rs1_i      (ID_Rs1),
        .id_rs2_i      (ID_Rs2),
        .id_rs1_used_i (ID_Rs1_used),
        .id_rs2_used_i (ID_Rs2_used),
        .ex_rd_i       (EX_Rd),
        .ex_mem_read_i (EX_MemRead),
        .lu_o          (lu)
    );

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        req        = 1'b0;
        case (state_q)
            ST_RUN: begin
                req = MEM_MemAccess;
                if (MEM_MemAccess && !dmem_ack_i) begin
                    freeze     = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_WAIT: begin
                // The request stays up until acked even if MEM_MemAccess drops,
                // since the pipeline is frozen on this access.
                req = 1'b1;
                if (dmem_ack_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
            end
            ST_ERR: begin
                // Dead until reset; a late ack is deliberately ignored.
                freeze = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux: freeze > branch > load-use > normal
    // ------------------------------------------------------------------
    assign sel_branch = !freeze && EX_BranchTaken;
    assign sel_lu     = !freeze && !EX_BranchTaken && lu;

    always_comb begin
        ctrl = CTRL_NONE;
        if (!rst_i) begin
            ctrl = CTRL_NOP;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (sel_branch) begin
            ctrl = CTRL_BRANCH;
        end else if (sel_lu) begin
            ctrl = CTRL_LU;
        end
    end

    assign dmem_req_o   = rst_i && req;
    assign PCWrite      = ctrl.pc_write;
    assign IFID_Write   = ctrl.ifid_write;
    assign IFID_Flush   = ctrl.ifid_flush;
    assign IDEX_Write   = ctrl.idex_write;
    assign IDEX_Bubble  = ctrl.idex_bubble;
    assign EXMEM_Write  = ctrl.exmem_write;
    assign MEMWB_Bubble = ctrl.memwb_bubble;
    assign err_o        = (state_q == ST_ERR);

    // ------------------------------------------------------------------
    // Saturating performance counters: [0]=load-use, [1]=flush, [2]=freeze
    // ------------------------------------------------------------------
    logic [2:0] cnt_inc;
    assign cnt_inc = {freeze, sel_branch, sel_lu};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt_o  = gen_cnt[0].cnt_q;
    assign flush_cnt_o  = gen_cnt[1].cnt_q;
    assign mstall_cnt_o = gen_cnt[2].cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [4:0]       ID_Rs1 = '0, ID_Rs2 = '0, EX_Rd = '0;
    logic             ID_Rs1_used = 0, ID_Rs2_used = 0, EX_MemRead = 0;
    logic             EX_BranchTaken = 0, MEM_MemAccess = 0, dmem_ack_i = 0;
    logic             dmem_req_o, PCWrite, IFID_Write, IFID_Flush, IDEX_Write;
    logic             IDEX_Bubble, EXMEM_Write, MEMWB_Bubble, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, mstall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_pending, m_err;
    int m_waited, m_stall, m_flush, m_mstall;

    always #5 clk_i = ~clk_i;

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rs1_used(ID_Rs1_used), .ID_Rs2_used(ID_Rs2_used),
        .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
        .MEM_MemAccess(MEM_MemAccess), .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write),
        .MEMWB_Bubble(MEMWB_Bubble), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .mstall_cnt_o(mstall_cnt_o)
    );

    function automatic logic [7:0] obs_ctrl();
        return {dmem_req_o, PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
                IDEX_Bubble, EXMEM_Write, MEMWB_Bubble};
    endfunction

    function automatic logic [8:0] obs_cnt();
        return {stall_cnt_o, flush_cnt_o, mstall_cnt_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic br, input logic ma, input logic ack);
        ID_Rs1 = rs1; ID_Rs1_used = u1; ID_Rs2 = rs2; ID_Rs2_used = u2;
        EX_Rd = rd; EX_MemRead = mr; EX_BranchTaken = br;
        MEM_MemAccess = ma; dmem_ack_i = ack;
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Entered at posedge+1 with inputs already applied; leaves at next posedge+1.
    task automatic cycle();
        bit lu, busy, frz, req;
        logic [6:0] exp_ctrl;
        #4;
        lu   = EX_MemRead && (EX_Rd != 0) &&
               ((ID_Rs1_used && ID_Rs1 == EX_Rd) || (ID_Rs2_used && ID_Rs2 == EX_Rd));
        busy = m_pending || MEM_MemAccess;
        frz  = m_err || (busy && !dmem_ack_i);
        req  = !m_err && busy;
        // order: pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble
        if (frz)                 exp_ctrl = 7'b0000001;
        else if (EX_BranchTaken) exp_ctrl = 7'b1111110;
        else if (lu)             exp_ctrl = 7'b0001110;
        else                     exp_ctrl = 7'b1101010;
        check("ctrl", 32'(obs_ctrl()), 32'({req, exp_ctrl}));
        check("cnt", 32'(obs_cnt()), 32'({m_stall[2:0], m_flush[2:0], m_mstall[2:0]}));
        check("err", 32'(err_o), 32'(m_err));
        if (frz) begin
            m_mstall = sat(m_mstall);
            if (!m_err) begin
                m_waited++;
                m_pending = 1'b1;
                if (m_waited == TIMEOUT) m_err = 1'b1;
            end
        end else begin
            m_pending = 1'b0;
            m_waited  = 0;
            if (EX_BranchTaken) m_flush = sat(m_flush);
            else if (lu)        m_stall = sat(m_stall);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Async reset asserted mid-cycle; released one edge later at posedge+1.
    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        check("rst_ctrl", 32'(obs_ctrl()), 32'h0);
        check("rst_cnt", 32'(obs_cnt()), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_hold", 32'(obs_ctrl()), 32'h0);
        rst_i = 1'b1;
        m_pending = 0; m_err = 0; m_waited = 0;
        m_stall = 0; m_flush = 0; m_mstall = 0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        do_reset();

        // 1: reset while waiting on memory
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();
        #2;
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // 2: load-use via rs2, then the two non-hazard variants
        set_in(1, 1, 5, 1, 5, 1, 0, 0, 0);
        cycle();
        check("t2_stall", 32'(stall_cnt_o), 32'd1);
        set_in(0, 1, 0, 1, 0, 1, 0, 0, 0);
        cycle();
        set_in(1, 1, 5, 0, 5, 1, 0, 0, 0);
        cycle();
        check("t2_nostall", 32'(stall_cnt_o), 32'd1);

        // 3: branch together with load-use
        set_in(1, 1, 5, 1, 5, 1, 1, 0, 0);
        cycle();
        check("t3_cnt", 32'({flush_cnt_o, stall_cnt_o}), 32'({3'd1, 3'd1}));

        // 4: three wait cycles then ack, then a zero-wait access
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t4_mstall", 32'(mstall_cnt_o), 32'd3);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        check("t4_zw", 32'(mstall_cnt_o), 32'd3);

        // 5: timeout into ERR, late ack ignored
        do_reset();
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle();
        end
        check("t5_err", 32'({err_o, dmem_req_o}), 32'b10);
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cycle();
        check("t5_sticky", 32'({err_o, PCWrite}), 32'b10);

        // 6: counter saturation
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(3, 1, 0, 0, 3, 1, 0, 0, 0);
            cycle();
        end
        check("t6_sat", 32'(stall_cnt_o), 32'd7);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_in(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) < 4));
            cycle();
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
